// File: rtl/inv_key_expansion.sv
// AES inverse key schedule: rebuilds the expanded key backwards from its last Nk words
// and streams round keys Nr..0 over a valid/ready handshake.
module inv_key_expansion #(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [0:Nk*32-1] last_key,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [0:127]     rk_out,
    output logic [3:0]       rk_round,
    output logic             done
);

    localparam int BASE0 = 4 * (Nr + 1) - Nk;

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, EMIT, STEP} state_t;

    state_t          state_reg;
    logic [31:0]     w_reg [Nk];
    logic [5:0]      base_reg;
    logic [3:0]      rnd_reg;
    logic            rk_valid_reg;
    logic            done_reg;
    logic [0:127]    rk_out_reg;
    logic [3:0]      rk_round_reg;

    function automatic logic [7:0] rcon(input logic [3:0] j);
        case (j)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    // Word being undone is w[i]; the recovered word is w[i-Nk] = w[i] ^ g(w[i-1]).
    logic [5:0]       idx_i;
    logic             is_rot;
    logic             is_sub8;
    logic [31:0]      g_in;
    logic [31:0]      sub_in;
    logic [31:0]      sub_out;
    logic [31:0]      g_out;
    logic [31:0]      new_word;
    logic [31:0]      w_shift [Nk];
    logic [0:Nk*32-1] w_flat;
    logic [0:Nk*32-1] shift_flat;

    assign idx_i    = base_reg + 6'(Nk - 1);
    assign is_rot   = (int'(idx_i) % Nk) == 0;
    assign is_sub8  = (Nk == 8) && ((int'(idx_i) % Nk) == 4);
    assign g_in     = w_reg[Nk-2];
    assign sub_in   = is_rot ? {g_in[23:0], g_in[31:24]} : g_in;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            assign sub_out[gi*8 +: 8] = SBOX[{sub_in[gi*8 +: 8], 3'b000} +: 8];
        end
    endgenerate

    always_comb begin
        g_out = g_in;
        if (is_rot)
            g_out = sub_out ^ {rcon(4'(int'(idx_i) / Nk)), 24'h000000};
        else if (is_sub8)
            g_out = sub_out;
    end

    assign new_word = w_reg[Nk-1] ^ g_out;

    generate
        for (genvar gi = 0; gi < Nk; gi++) begin : g_window
            if (gi == 0) begin : g_head
                assign w_shift[gi] = new_word;
            end else begin : g_tail
                assign w_shift[gi] = w_reg[gi-1];
            end
            assign w_flat[gi*32 +: 32]     = w_reg[gi];
            assign shift_flat[gi*32 +: 32] = w_shift[gi];
        end
    endgenerate

    // 7-bit arithmetic so the window comparisons never wrap.
    logic [6:0] rnd4;
    logic [6:0] rnd4_dec;
    logic [6:0] base7;
    logic       emit_next_ok;
    logic       step_done;
    logic [2:0] off_emit;
    logic [2:0] off_step;

    assign rnd4         = {1'b0, rnd_reg, 2'b00};
    assign rnd4_dec     = {1'b0, rnd_reg - 4'd1, 2'b00};
    assign base7        = {1'b0, base_reg};
    assign emit_next_ok = rnd4_dec >= base7;
    assign step_done    = (rnd4 + 7'd1) >= base7;
    assign off_emit     = 3'(rnd4_dec - base7);
    assign off_step     = 3'(rnd4 + 7'd1 - base7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            base_reg     <= '0;
            rnd_reg      <= '0;
            rk_valid_reg <= 1'b0;
            done_reg     <= 1'b0;
            rk_out_reg   <= '0;
            rk_round_reg <= '0;
            for (int k = 0; k < Nk; k++)
                w_reg[k] <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < Nk; k++)
                            w_reg[k] <= last_key[k*32 +: 32];
                        base_reg     <= 6'(BASE0);
                        rnd_reg      <= 4'(Nr);
                        state_reg    <= EMIT;
                        rk_valid_reg <= 1'b1;
                        rk_out_reg   <= last_key[(Nk-4)*32 +: 128];
                        rk_round_reg <= 4'(Nr);
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        if (rnd_reg == 4'd0) begin
                            state_reg    <= IDLE;
                            rk_valid_reg <= 1'b0;
                            done_reg     <= 1'b1;
                        end else begin
                            rnd_reg <= rnd_reg - 4'd1;
                            if (emit_next_ok) begin
                                rk_out_reg   <= w_flat[{off_emit, 5'b00000} +: 128];
                                rk_round_reg <= rnd_reg - 4'd1;
                            end else begin
                                state_reg    <= STEP;
                                rk_valid_reg <= 1'b0;
                            end
                        end
                    end
                end
                STEP: begin
                    for (int k = 0; k < Nk; k++)
                        w_reg[k] <= w_shift[k];
                    base_reg <= base_reg - 6'd1;
                    if (step_done) begin
                        state_reg    <= EMIT;
                        rk_valid_reg <= 1'b1;
                        rk_out_reg   <= shift_flat[{off_step, 5'b00000} +: 128];
                        rk_round_reg <= rnd_reg;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy     = state_reg != IDLE;
    assign rk_valid = rk_valid_reg;
    assign rk_out   = rk_out_reg;
    assign rk_round = rk_round_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_inv_key_expansion.sv
// Bench for inv_key_expansion: one instance per key size, checked against a forward
// key-expansion model built on an algebraically derived S-box.
module tb_inv_key_expansion;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic [2:0]             start;
    logic [2:0]             rk_ready;
    logic [2:0][255:0]      lk_p;
    logic [2:0]             busy;
    logic [2:0]             rk_valid;
    logic [2:0]             done;
    logic [2:0][127:0]      rk_out_p;
    logic [2:0][3:0]        rk_round_p;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int NK = 4 + 2 * gi;
            inv_key_expansion #(.Nk(NK)) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .start    (start[gi]),
                .last_key (lk_p[gi][255 -: NK*32]),
                .busy     (busy[gi]),
                .rk_valid (rk_valid[gi]),
                .rk_ready (rk_ready[gi]),
                .rk_out   (rk_out_p[gi]),
                .rk_round (rk_round_p[gi]),
                .done     (done[gi])
            );
        end
    endgenerate

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  sbox_m [256];
    logic [31:0] exp_w  [60];
    logic [127:0] obs_key [15];
    int hs_cyc [15];
    int done_cyc;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
    endfunction

    task automatic expand(input int nk, input logic [255:0] key);
        int total = 4 * (nk + 7);
        for (int i = 0; i < total; i++) begin
            if (i < nk) begin
                exp_w[i] = key[255 - 32*i -: 32];
            end else begin
                logic [31:0] t = exp_w[i-1];
                if (i % nk == 0) begin
                    logic [7:0] rc = 8'h01;
                    for (int j = 1; j < i / nk; j++) rc = xtime(rc);
                    t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                end else if (nk == 8 && i % nk == 4) begin
                    t = subw(t);
                end
                exp_w[i] = exp_w[i-nk] ^ t;
            end
        end
    endtask

    function automatic logic [127:0] exp_round(input int r);
        return {exp_w[4*r], exp_w[4*r+1], exp_w[4*r+2], exp_w[4*r+3]};
    endfunction

    function automatic logic [255:0] model_last_key(input int nk);
        logic [255:0] v = '0;
        for (int j = 0; j < nk; j++)
            v[255 - 32*j -: 32] = exp_w[4*(nk+7) - nk + j];
        return v;
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] v;
        for (int j = 0; j < 8; j++) v[32*j +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- sequence runner ----------------
    task automatic run_seq(input int k, input bit rand_ready, input bit poke);
        int nk = 4 + 2 * k;
        int nr = nk + 6;
        int r, cyc, early_done;
        bit stalled, take;
        logic [127:0] held_key;
        logic [3:0]   held_rnd;
        @(negedge clk);
        lk_p[k]     = model_last_key(nk);
        start[k]    = 1'b1;
        rk_ready[k] = 1'b0;
        @(negedge clk);
        start[k] = 1'b0;
        cyc = 1; r = nr; stalled = 0; early_done = 0; done_cyc = -1;
        while (r >= 0 && cyc < 3000) begin
            if (done[k]) early_done++;
            if (rk_valid[k]) begin
                if (stalled) begin
                    check_eq($sformatf("stall_key_nk%0d", nk), rk_out_p[k], held_key);
                    check_eq($sformatf("stall_rnd_nk%0d", nk), {124'b0, rk_round_p[k]}, {124'b0, held_rnd});
                end
                take = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (take) begin
                    check_eq($sformatf("key_nk%0d_r%0d", nk, r), rk_out_p[k], exp_round(r));
                    check_eq($sformatf("round_nk%0d_r%0d", nk, r), {124'b0, rk_round_p[k]}, 128'(r));
                    obs_key[r] = rk_out_p[k];
                    hs_cyc[r]  = cyc;
                    r--;
                    stalled = 0;
                end else begin
                    held_key = rk_out_p[k];
                    held_rnd = rk_round_p[k];
                    stalled  = 1;
                end
                rk_ready[k] = take;
            end else begin
                rk_ready[k] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            start[k] = poke && busy[k] && ($urandom_range(0, 1) == 1);
            if (poke) lk_p[k] = rand_key();
            @(negedge clk);
            cyc++;
        end
        start[k]    = 1'b0;
        rk_ready[k] = 1'b0;
        check_eq($sformatf("timeout_nk%0d_rounds_left", nk), 128'(r + 1), 128'd0);
        done_cyc = cyc;
        check_eq($sformatf("done_pulse_nk%0d", nk), {127'b0, done[k]}, 128'd1);
        check_eq($sformatf("busy_fall_nk%0d", nk), {127'b0, busy[k]}, 128'd0);
        check_eq($sformatf("early_done_nk%0d", nk), 128'(early_done), 128'd0);
        @(negedge clk);
        check_eq($sformatf("done_once_nk%0d", nk), {127'b0, done[k]}, 128'd0);
    endtask

    // Reset during STEP of round 6 for the AES-128 instance.
    task automatic reset_abort();
        int cyc = 0;
        bit seen7 = 0;
        @(negedge clk);
        lk_p[0]  = model_last_key(4);
        start[0] = 1'b1;
        @(negedge clk);
        start[0]    = 1'b0;
        rk_ready[0] = 1'b1;
        while (!(seen7 && !rk_valid[0]) && cyc < 200) begin
            if (rk_valid[0] && rk_round_p[0] == 4'd7) seen7 = 1;
            @(negedge clk);
            cyc++;
        end
        check_eq("abort_reached_step", 128'(cyc < 200), 128'd1);
        check_eq("abort_busy_before", {127'b0, busy[0]}, 128'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_busy", {127'b0, busy[0]}, 128'd0);
        check_eq("abort_valid", {127'b0, rk_valid[0]}, 128'd0);
        check_eq("abort_rk_out", rk_out_p[0], 128'd0);
        check_eq("abort_rk_round", {124'b0, rk_round_p[0]}, 128'd0);
        check_eq("abort_done", {127'b0, done[0]}, 128'd0);
        rk_ready[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("abort_stays_idle", {127'b0, busy[0]}, 128'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = '0;
        rk_ready = '0;
        lk_p     = '0;
        build_sbox();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("rst_busy_%0d", k), {127'b0, busy[k]}, 128'd0);
            check_eq($sformatf("rst_valid_%0d", k), {127'b0, rk_valid[k]}, 128'd0);
            check_eq($sformatf("rst_out_%0d", k), rk_out_p[k], 128'd0);
            check_eq($sformatf("rst_round_%0d", k), {124'b0, rk_round_p[k]}, 128'd0);
            check_eq($sformatf("rst_done_%0d", k), {127'b0, done[k]}, 128'd0);
        end
        rst_n = 1'b1;

        // AES-128 FIPS-197
        expand(4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        run_seq(0, 0, 0);
        check_eq("fips128_r10", obs_key[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check_eq("fips128_r9", obs_key[9], 128'hac7766f319fadc2128d12941575c006e);
        check_eq("fips128_r0", obs_key[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        check_eq("aes128_first_lat", 128'(hs_cyc[10]), 128'd1);
        for (int r = 9; r >= 0; r--)
            check_eq($sformatf("aes128_gap_r%0d", r), 128'(hs_cyc[r] - hs_cyc[r+1]), 128'd5);
        check_eq("aes128_start_to_done", 128'(done_cyc), 128'd52);

        // AES-256
        expand(8, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
        run_seq(2, 0, 0);
        check_eq("aes256_r14_lat", 128'(hs_cyc[14]), 128'd1);
        check_eq("aes256_r13_b2b", 128'(hs_cyc[13]), 128'd2);
        check_eq("aes256_r12_lat", 128'(hs_cyc[12]), 128'd7);
        check_eq("aes256_r0", obs_key[0], 128'h603deb1015ca71be2b73aef0857d7781);

        // AES-192
        expand(6, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0});
        run_seq(1, 0, 0);
        check_eq("aes192_r12_lat", 128'(hs_cyc[12]), 128'd1);
        check_eq("aes192_r11_lat", 128'(hs_cyc[11]), 128'd4);
        check_eq("aes192_r0", obs_key[0], 128'h8e73b0f7da0e6452c810f32b809079e5);

        // Random keys with backpressure, then with start poked while busy
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 3; k++) begin
                expand(4 + 2 * k, rand_key());
                run_seq(k, 1, pass == 1);
            end
        end

        // Abort by reset, then a clean rerun
        expand(4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        reset_abort();
        run_seq(0, 0, 0);
        check_eq("rerun_r0", obs_key[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
